// File: rtl/sd_bd_pkg.sv
// ---------------------------------------------------------------------------
// sd_bd_pkg
// Shared definitions for the SD buffer-descriptor queue.
//   BD_WORDS   : words per buffer descriptor (sys_adr, cmd_arg)
//   WSEL_W     : width of the word-select field inside a RAM address
//   rd_state_t : read-side handshake states
//   bd_ptr_w() : pointer width for a given BD depth
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package sd_bd_pkg;

    localparam int BD_WORDS = 2;
    localparam int WSEL_W   = 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

    // A depth of one still needs a one-bit pointer so the RAM address is legal.
    function automatic int bd_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sd_bd_ram_2p.sv
// ---------------------------------------------------------------------------
// sd_bd_ram_2p
// Simple dual-port RAM holding the BD words: one write port, one read port
// with a registered output.
//   clk, rst     : clock, async active-high reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address; q updates on the next edge
//   q            : registered read data, holds its value when re is low
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sd_bd_ram_2p #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array has no reset so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_bd_queue.sv
// ---------------------------------------------------------------------------
// sd_bd_queue
// Buffer-descriptor queue between the host registers and the SD data master.
// Each BD is two words (sys_adr, cmd_arg). Host writes words one per cycle;
// the master reads the head BD with re_s/ack_o_s and retires it with a_cmp.
//   clk, rst   : clock, async active-high reset
//   we_m       : host write strobe, dat_in_m : host write word
//   bd_clr     : synchronous flush of pointers and counters
//   free_bd    : registered count of free BD entries
//   re_s       : master read request (held high)
//   ack_o_s    : one-cycle valid per word, dat_out_s : read word
//   a_cmp      : master completion pulse, retires the head BD
//   wr_err     : sticky, write attempted while full
//   cmp_err    : sticky, a_cmp while nothing is committed
//   err_clr    : clears both sticky flags
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sd_bd_queue
    import sd_bd_pkg::*;
#(
    parameter int BD_DEPTH = 8,
    parameter int DW       = 32,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_m,
    input  logic [DW-1:0] dat_in_m,
    input  logic          bd_clr,
    output logic [CW-1:0] free_bd,
    input  logic          re_s,
    output logic          ack_o_s,
    output logic [DW-1:0] dat_out_s,
    input  logic          a_cmp,
    output logic          wr_err,
    output logic          cmp_err,
    input  logic          err_clr
);

    localparam int PW = bd_ptr_w(BD_DEPTH);
    localparam int AW = PW + WSEL_W;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          hcnt;
    logic          rcnt;
    logic [CW-1:0] committed;
    logic [CW-1:0] committed_next;
    rd_state_t     state;

    logic wr_ok;
    logic commit;
    logic retire;
    logic wr_set;
    logic cmp_set;
    logic rd_issue;
    logic rd_word;

    // Write acceptance is judged on committed entries only; a half-written
    // BD always has its slot reserved because wr_ptr points at a free slot.
    always_comb begin
        wr_ok    = we_m && (free_bd != '0);
        commit   = wr_ok && hcnt;
        retire   = a_cmp && (committed != '0);
        wr_set   = !bd_clr && we_m && (free_bd == '0);
        cmp_set  = !bd_clr && a_cmp && (committed == '0);
        // Word 0 is issued directly from idle so the first ack follows the
        // sampled request by one cycle; the second word comes from R_READ.
        rd_issue = !bd_clr && re_s && (committed != '0) &&
                   ((state == R_IDLE) || (state == R_READ));
        rd_word  = (state == R_IDLE) ? 1'b0 : rcnt;
    end

    // Commit and retire in the same cycle cancel out.
    always_comb begin
        committed_next = committed;
        if (commit && !retire) begin
            committed_next = committed + CW'(1);
        end else if (!commit && retire) begin
            committed_next = committed - CW'(1);
        end
    end

    sd_bd_ram_2p #(
        .DEPTH(BD_WORDS * BD_DEPTH),
        .DW   (DW),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok && !bd_clr),
        .waddr({wr_ptr, hcnt}),
        .wdata(dat_in_m),
        .re   (rd_issue),
        .raddr({rd_ptr, rd_word}),
        .q    (dat_out_s)
    );

    // Pointers, counters, read FSM and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hcnt      <= 1'b0;
            rcnt      <= 1'b0;
            committed <= '0;
            free_bd   <= CW'(BD_DEPTH);
            state     <= R_IDLE;
            ack_o_s   <= 1'b0;
            wr_err    <= 1'b0;
            cmp_err   <= 1'b0;
        end else begin
            // A new error in the same cycle as err_clr must survive.
            wr_err  <= wr_set  || (wr_err  && !err_clr);
            cmp_err <= cmp_set || (cmp_err && !err_clr);

            if (bd_clr) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                hcnt      <= 1'b0;
                rcnt      <= 1'b0;
                committed <= '0;
                free_bd   <= CW'(BD_DEPTH);
                state     <= R_IDLE;
                ack_o_s   <= 1'b0;
            end else begin
                if (wr_ok) begin
                    hcnt <= ~hcnt;
                end
                if (commit) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                committed <= committed_next;
                free_bd   <= CW'(BD_DEPTH) - committed_next;
                ack_o_s   <= rd_issue;

                case (state)
                    R_IDLE: begin
                        if (rd_issue) begin
                            rcnt  <= 1'b1;
                            state <= R_READ;
                        end
                    end
                    R_READ: begin
                        if (rd_issue) begin
                            if (rcnt) begin
                                state <= R_HOLD;
                            end else begin
                                rcnt <= 1'b1;
                            end
                        end else begin
                            rcnt  <= 1'b0;
                            state <= R_IDLE;
                        end
                    end
                    R_HOLD: begin
                        if (!re_s) begin
                            rcnt  <= 1'b0;
                            state <= R_IDLE;
                        end
                    end
                    default: begin
                        rcnt  <= 1'b0;
                        state <= R_IDLE;
                    end
                endcase

                // Retiring moves the head; the next read starts at word 0.
                if (retire) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    rcnt   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_bd_queue.sv
// ---------------------------------------------------------------------------
// tb_sd_bd_queue
// Directed self-checking bench for sd_bd_queue. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge acts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sd_bd_queue;

    localparam int BD_DEPTH = 8;
    localparam int DW       = 32;
    localparam int CW       = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we_m;
    logic [DW-1:0] dat_in_m;
    logic          bd_clr;
    logic [CW-1:0] free_bd;
    logic          re_s;
    logic          ack_o_s;
    logic [DW-1:0] dat_out_s;
    logic          a_cmp;
    logic          wr_err;
    logic          cmp_err;
    logic          err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sd_bd_queue #(
        .BD_DEPTH(BD_DEPTH),
        .DW      (DW),
        .CW      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_m     (we_m),
        .dat_in_m (dat_in_m),
        .bd_clr   (bd_clr),
        .free_bd  (free_bd),
        .re_s     (re_s),
        .ack_o_s  (ack_o_s),
        .dat_out_s(dat_out_s),
        .a_cmp    (a_cmp),
        .wr_err   (wr_err),
        .cmp_err  (cmp_err),
        .err_clr  (err_clr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] dat, input logic re,
                                 input logic cmp, input logic clr, input logic eclr);
        we_m     = we;
        dat_in_m = dat;
        re_s     = re;
        a_cmp    = cmp;
        bd_clr   = clr;
        err_clr  = eclr;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeBd(input logic [31:0] w0, input logic [31:0] w1);
        applyStimulus(1'b1, w0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, w1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    // Raises re_s and expects exactly two acks; leaves re_s high (FSM in hold).
    task automatic readBd(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, " ack0"}, 32'(ack_o_s), 32'd1);
        checkOutput({tag, " dat0"}, dat_out_s, e0);
        tick();
        checkOutput({tag, " ack1"}, 32'(ack_o_s), 32'd1);
        checkOutput({tag, " dat1"}, dat_out_s, e1);
        tick();
        checkOutput({tag, " no ack2"}, 32'(ack_o_s), 32'd0);
    endtask

    task automatic retireBd();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) tick();
        checkOutput("rst free_bd", 32'(free_bd), 32'd8);
        checkOutput("rst ack", 32'(ack_o_s), 32'd0);
        checkOutput("rst dat", dat_out_s, 32'h0);
        checkOutput("rst wr_err", 32'(wr_err), 32'd0);
        checkOutput("rst cmp_err", 32'(cmp_err), 32'd0);
        rst = 1'b0;
        tick();

        // Empty queue: request is held but nothing is served.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("empty no ack", 32'(ack_o_s), 32'd0);
        end
        idle();
        tick();

        // Single BD write, read and complete.
        writeBd(32'h1000_0000, 32'h0000_0040);
        checkOutput("one bd free", 32'(free_bd), 32'd7);
        readBd("one bd", 32'h1000_0000, 32'h0000_0040);
        tick();
        checkOutput("one bd held no ack", 32'(ack_o_s), 32'd0);
        retireBd();
        checkOutput("one bd retired free", 32'(free_bd), 32'd8);

        // Retry: dropping re_s without a_cmp re-serves the same BD.
        writeBd(32'hAAAA_0001, 32'hAAAA_0002);
        writeBd(32'hBBBB_0001, 32'hBBBB_0002);
        checkOutput("two bd free", 32'(free_bd), 32'd6);
        readBd("retry first", 32'hAAAA_0001, 32'hAAAA_0002);
        idle();
        tick();
        readBd("retry again", 32'hAAAA_0001, 32'hAAAA_0002);
        retireBd();
        checkOutput("retry free", 32'(free_bd), 32'd7);
        readBd("retry next", 32'hBBBB_0001, 32'hBBBB_0002);
        retireBd();
        checkOutput("retry drained", 32'(free_bd), 32'd8);

        // Fill to full, overflow, then commit and retire together.
        for (int i = 0; i < BD_DEPTH; i++) begin
            writeBd(32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i));
        end
        checkOutput("full free", 32'(free_bd), 32'd0);
        checkOutput("full no wr_err", 32'(wr_err), 32'd0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("overflow wr_err", 32'(wr_err), 32'd1);
        checkOutput("overflow free", 32'(free_bd), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("wr_err cleared", 32'(wr_err), 32'd0);
        retireBd();
        checkOutput("after retire free", 32'(free_bd), 32'd1);
        applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("half bd free", 32'(free_bd), 32'd1);
        applyStimulus(1'b1, 32'h4000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("commit+cmp free", 32'(free_bd), 32'd1);
        readBd("full head", 32'h2000_0002, 32'h3000_0002);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("flush free", 32'(free_bd), 32'd8);
        checkOutput("flush ack", 32'(ack_o_s), 32'd0);

        // Wrap: 20 BDs through an 8-entry queue keep their order.
        for (int i = 0; i < 20; i++) begin
            writeBd(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
            readBd($sformatf("wrap %0d", i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
            retireBd();
        end
        checkOutput("wrap free", 32'(free_bd), 32'd8);

        // Completion with nothing committed.
        retireBd();
        checkOutput("cmp_err set", 32'(cmp_err), 32'd1);
        checkOutput("cmp_err free", 32'(free_bd), 32'd8);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("cmp_err set wins", 32'(cmp_err), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("cmp_err cleared", 32'(cmp_err), 32'd0);

        // Flush in the middle of a read.
        writeBd(32'h5000_0000, 32'h5000_0001);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("clr pre ack", 32'(ack_o_s), 32'd1);
        checkOutput("clr pre dat", dat_out_s, 32'h5000_0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("clr ack stops", 32'(ack_o_s), 32'd0);
        checkOutput("clr free", 32'(free_bd), 32'd8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("clr stays quiet", 32'(ack_o_s), 32'd0);
        idle();
        tick();

        // Asynchronous reset in the middle of a read.
        writeBd(32'h6000_0000, 32'h6000_0001);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("arst pre ack", 32'(ack_o_s), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst ack", 32'(ack_o_s), 32'd0);
        checkOutput("arst free", 32'(free_bd), 32'd8);
        checkOutput("arst dat", dat_out_s, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("arst after ack", 32'(ack_o_s), 32'd0);
        checkOutput("arst after free", 32'(free_bd), 32'd8);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_bd_queue.md
Name: sd_bd_queue

Overview:
- Buffer-descriptor (BD) queue that serves the SD data master.
- Software writes BDs through the host-register side. Each BD is 2 × 32-bit words: word0 = sys_adr, word1 = cmd_arg.
- The data master reads the head BD with a re/ack handshake and retires it with a one-cycle completion pulse.
- One instance serves the TX channel and one serves the RX channel. The instance drives free_bd, re/ack data and accepts a_cmp.

Parameters:
- BD_DEPTH, 8, number of BD entries; must be a power of two.
- DW, 32, RAM word width; a BD is 2 words.
- CW, 4, width of free_bd; equals clog2(BD_DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- we_m  in  1  host write strobe, one word per cycle.
- dat_in_m  in  DW  host write data.
- bd_clr  in  1  synchronous flush of all entries and pointers.
- free_bd  out  CW  number of free entries; equals BD_DEPTH when the queue is empty.
- re_s  in  1  master read request, held high.
- ack_o_s  out  1  read-data valid, one pulse per word.
- dat_out_s  out  DW  read data.
- a_cmp  in  1  master completion pulse; retires the head BD.
- wr_err  out  1  sticky flag: write attempted while full.
- cmp_err  out  1  sticky flag: a_cmp received with no committed BD.
- err_clr  in  1  clears wr_err and cmp_err.

Behaviour:
- Reset values: free_bd = BD_DEPTH; ack_o_s = 0; dat_out_s = 0; wr_err = 0; cmp_err = 0. Write and read pointers = 0; word counters = 0; state = R_IDLE.
- Write side:
  - A host word counter alternates 0/1. The word is stored at {wr_ptr, hcnt}.
  - On the second word the BD is committed: wr_ptr increments (wraps modulo BD_DEPTH) and the committed count increments.
  - A write while free_bd == 0 is dropped, sets wr_err, and leaves hcnt unchanged.
  - A half-written BD is not visible to the reader and does not affect free_bd.
- free_bd = BD_DEPTH − committed.
  - Commit and a_cmp in the same cycle: free_bd is unchanged.
  - free_bd is updated the cycle after the event (registered).
- Read FSM:
  - R_IDLE → R_READ when re_s = 1 and committed > 0.
  - R_READ: issues word rcnt of the head BD. ack_o_s and dat_out_s are registered, so latency from re_s sampled high to ack is 1 cycle.
    - Words are issued on consecutive cycles while re_s = 1.
    - After rcnt = 1 is issued → R_HOLD. No third ack is ever issued, even if re_s stays high.
  - R_HOLD: waits. re_s = 0 → R_IDLE with rcnt cleared; the head pointer is unchanged, so a retried transfer re-reads the same BD.
  - re_s falling in R_READ → R_IDLE, rcnt cleared.
- a_cmp in any state:
  - If committed > 0: rd_ptr increments (with wrap), committed decrements, rcnt clears.
  - If committed = 0: ignored, and cmp_err is set.
- bd_clr takes priority over everything in the same cycle:
  - Pointers, hcnt, rcnt, committed = 0; free_bd = BD_DEPTH; FSM → R_IDLE; ack_o_s = 0.
  - RAM contents are not cleared.
- Reset mid-transfer: all state returns to reset values immediately; no ack pulse completes.
- Write to the same RAM address as a concurrent read: not possible, because the write targets a non-committed slot.
- err_clr clears both flags. If a new error event occurs in the same cycle as err_clr, the set wins.

Decomposition:
- sd_bd_pkg holds:
  - BD_WORDS = 2.
  - Read-FSM state enum {R_IDLE, R_READ, R_HOLD}.
  - Pointer-width constant.
- Sub-module sd_bd_ram_2p: simple dual-port RAM with 2·BD_DEPTH × DW words, registered read port and one write port.
- The top level holds the pointers, counters, FSM and flags.

Test Plan:
- Reset then idle → free_bd = 8, ack_o_s = 0, no acks with re_s = 1.
- Write 0x1000_0000 and 0x0000_0040, then hold re_s → free_bd = 7. Acks on 2 consecutive cycles carry 0x1000_0000 then 0x0000_0040; no third ack. a_cmp → free_bd = 8.
- Read the BD, drop re_s without a_cmp, then raise re_s again → the same two words are re-served. Then a_cmp → rd_ptr advances.
- Fill 8 BDs, then write a 9th word → wr_err = 1, free_bd = 0. Same cycle as a later commit plus a_cmp → free_bd holds.
- Wrap test: 20 BDs written and completed in sequence → data order is preserved across the pointer wrap.
- a_cmp with queue empty → cmp_err = 1. bd_clr asserted in R_READ → ack stops next cycle, free_bd = 8.
